// File: rtl/ic_serr_slave.sv
// ic_serr_slave -- default (error) slave behind the interconnect address decode.
// Any AW/AR routed to the error slave index ends up here. Writes are accepted,
// all W beats drained, then a DECERR write response is issued. Reads return
// ARLEN+1 beats of DECERR with RLAST on the last one. The master side is always
// brought to a clean handshake so a bad address can never hang the fabric.
//
// Build option: IC_SERR_PATTERN_EN -- when defined RDATA carries 32'hDEADBEEF in
// every 32-bit lane; when undefined RDATA is zero.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   AWID/AWLEN/AWVALID/AWREADY    write address channel (AWLEN unused, WLAST ends burst)
//   WDATA/WLAST/WVALID/WREADY     write data channel (data discarded)
//   BID/BRESP/BVALID/BREADY       write response channel (BRESP = DECERR)
//   ARID/ARLEN/ARVALID/ARREADY    read address channel
//   RID/RDATA/RRESP/RLAST/        read data channel (RRESP = DECERR)
//   RVALID/RREADY
//
// Write FSM
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for an address
//   W_DATA | WREADY high, dropping beats until WLAST
//   W_RESP | BVALID high with captured ID until BREADY
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY high, waiting for an address
//   R_DATA | RVALID high, beat counter counts down to 0 (RLAST)

module ic_serr_slave #(
   parameter int ID_BITS   = 4,
   parameter int DATA_BITS = 32,
   parameter int LEN_BITS  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ID_BITS-1:0]   AWID,
   input  logic [LEN_BITS-1:0]  AWLEN,
   input  logic                 AWVALID,
   output logic                 AWREADY,
   input  logic [DATA_BITS-1:0] WDATA,
   input  logic                 WLAST,
   input  logic                 WVALID,
   output logic                 WREADY,
   output logic [ID_BITS-1:0]   BID,
   output logic [1:0]           BRESP,
   output logic                 BVALID,
   input  logic                 BREADY,
   input  logic [ID_BITS-1:0]   ARID,
   input  logic [LEN_BITS-1:0]  ARLEN,
   input  logic                 ARVALID,
   output logic                 ARREADY,
   output logic [ID_BITS-1:0]   RID,
   output logic [DATA_BITS-1:0] RDATA,
   output logic [1:0]           RRESP,
   output logic                 RLAST,
   output logic                 RVALID,
   input  logic                 RREADY
);

   localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef IC_SERR_PATTERN_EN
   localparam logic [DATA_BITS-1:0] RDATA_BEAT = {(DATA_BITS/32){32'hDEADBEEF}};
`else
   localparam logic [DATA_BITS-1:0] RDATA_BEAT = '0;
`endif

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   w_state_t             w_state_q, w_state_d;
   logic [ID_BITS-1:0]   bid_q, bid_d;

   r_state_t             r_state_q, r_state_d;
   logic [LEN_BITS-1:0]  r_cnt_q, r_cnt_d;
   logic [ID_BITS-1:0]   rid_q, rid_d;
   logic [DATA_BITS-1:0] rdata_q, rdata_d;

   // Burst length and write data are intentionally ignored.
   logic unused_inputs;
   assign unused_inputs = ^{AWLEN, WDATA};

   // ---------------- write side ----------------
   always_comb begin
      w_state_d = w_state_q;
      bid_d     = bid_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (AWVALID) begin
               bid_d     = AWID;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (WVALID && WLAST) begin
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         bid_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         bid_q     <= bid_d;
      end
   end

   assign AWREADY = (w_state_q == W_IDLE);
   assign WREADY  = (w_state_q == W_DATA);
   assign BVALID  = (w_state_q == W_RESP);
   assign BID     = bid_q;
   assign BRESP   = RESP_DECERR;

   // ---------------- read side ----------------
   // r_cnt_q holds the beats remaining after the current one; 0 marks RLAST.
   always_comb begin
      r_state_d = r_state_q;
      r_cnt_d   = r_cnt_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (ARVALID) begin
               rid_d     = ARID;
               r_cnt_d   = ARLEN;
               rdata_d   = RDATA_BEAT;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (RREADY) begin
               if (r_cnt_q == '0) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d = r_cnt_q - 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_cnt_q   <= '0;
         rid_q     <= '0;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_cnt_q   <= r_cnt_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign ARREADY = (r_state_q == R_IDLE);
   assign RVALID  = (r_state_q == R_DATA);
   assign RLAST   = (r_state_q == R_DATA) && (r_cnt_q == '0);
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = RESP_DECERR;

endmodule
